// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: ALU operation codes, divider state encoding
// and the core's configured divide width.
package picomips_pkg;

    // Data-path width of the core; the divider runs one iteration per bit.
    localparam int DIV_ITER = 8;

    typedef enum logic [2:0] {
        RA       = 3'd0,
        RB       = 3'd1,
        RADD     = 3'd2,
        RSUB     = 3'd3,
        RMULT    = 3'd4,
        RDIVIDED = 3'd5
    } alu_code_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {P,Q} left, then subtract the
// divisor from P and set the new quotient bit if it fits.
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   p,
    input  logic [N-1:0] q,
    input  logic [N-1:0] divisor,
    output logic [N:0]   p_next,
    output logic [N-1:0] q_next
);

    logic [2*N:0] pq_sh;
    logic [N:0]   p_sh;
    logic [N:0]   diff;

    // Shift, trial-subtract in N+1 bits, restore when the divisor does not fit.
    always_comb begin
        pq_sh  = {p, q} << 1;
        p_sh   = pq_sh[2*N:N];
        diff   = p_sh - {1'b0, divisor};
        q_next = pq_sh[N-1:0];
        p_next = p_sh;
        if (p_sh >= {1'b0, divisor}) begin
            p_next    = diff;
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned divider for the picoMIPS core. Stalls the PC while the
// restoring iterations run and pulses done for the register-file write.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; start here latches operands and stalls
//   RUN   | one restoring step per cycle, N cycles, PC stalled
//   DONE  | results valid, done pulse, PC released; start ignored
module div_sequencer
    import picomips_pkg::*;
#(
    parameter int N = DIV_ITER
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         stall,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_t state, state_next;

    logic [N:0]    p_reg;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  dvs_reg;
    logic [CW-1:0] cnt;
    logic [N:0]    p_step;
    logic [N-1:0]  q_step;
    logic          accept;
    logic          zero_dvs;

    assign zero_dvs = (divisor == '0);

    div_step #(.N(N)) u_step (
        .p       (p_reg),
        .q       (q_reg),
        .divisor (dvs_reg),
        .p_next  (p_step),
        .q_next  (q_step)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, accept strobe and combinational stall.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = zero_dvs ? DONE : RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration registers and held results.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state_next == DONE);
            if (accept) begin
                p_reg       <= '0;
                q_reg       <= dividend;
                dvs_reg     <= divisor;
                cnt         <= '0;
                div_by_zero <= zero_dvs;
                if (zero_dvs) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == RUN) begin
                p_reg <= p_step;
                q_reg <= q_step;
                cnt   <= cnt + 1'b1;
                if (cnt == LAST) begin
                    quotient  <= q_step;
                    remainder <= p_step[N-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a cycle-level reference model built
// from plain division arithmetic and accept/done timing.
module tb_div_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         stall;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    div_sequencer #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .stall       (stall),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int last_done_cyc = 0;

    // Model: when the last accept happened, when its done falls, when the
    // unit is free again, and the result visible before and after done.
    int           m_free_at = 0;
    int           m_acc     = -1;
    int           m_done    = -1;
    logic [N-1:0] m_old_q = '0, m_old_r = '0, m_new_q = '0, m_new_r = '0;
    logic         m_old_z = 1'b0, m_new_z = 1'b0;

    function automatic logic [N-1:0] vis_q(int c);
        return (c >= m_done) ? m_new_q : m_old_q;
    endfunction

    function automatic logic [N-1:0] vis_r(int c);
        return (c >= m_done) ? m_new_r : m_old_r;
    endfunction

    function automatic logic vis_z(int c);
        return (c > m_acc) ? m_new_z : m_old_z;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update on each rising edge, from the inputs of the ending cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_free_at = cyc + 1;
            m_acc     = -1;
            m_done    = -1;
            m_old_q   = '0;
            m_old_r   = '0;
            m_new_q   = '0;
            m_new_r   = '0;
            m_old_z   = 1'b0;
            m_new_z   = 1'b0;
        end else if (cyc >= m_free_at && start) begin
            m_old_q = vis_q(cyc);
            m_old_r = vis_r(cyc);
            m_old_z = vis_z(cyc);
            m_acc   = cyc;
            if (divisor == '0) begin
                m_new_q = '1;
                m_new_r = dividend;
                m_new_z = 1'b1;
                m_done  = cyc + 1;
            end else begin
                m_new_q = dividend / divisor;
                m_new_r = dividend % divisor;
                m_new_z = 1'b0;
                m_done  = cyc + N + 1;
            end
            m_free_at = m_done + 1;
        end
        cyc = cyc + 1;
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit idle = (cyc >= m_free_at);
            check("stall", 32'(stall), idle ? 32'(start) : 32'(cyc < m_done));
            check("done", 32'(done), 32'(cyc == m_done));
            check("div_by_zero", 32'(div_by_zero), 32'(vis_z(cyc)));
            if (!(cyc > m_acc && cyc < m_done)) begin
                check("quotient", 32'(quotient), 32'(vis_q(cyc)));
                check("remainder", 32'(remainder), 32'(vis_r(cyc)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide from an idle cycle, wait for done, pin literal results.
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic ez, input int elat,
                          input bit scramble, input bit keep);
        int lat;
        bit got;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        got      = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                tick();
                lat++;
                if (scramble && lat == 3) begin
                    dividend = ~a;
                    divisor  = b + 8'd3;
                end
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout: no done within %0d cycles for %0d/%0d", lat, a, b);
        end else begin
            check("latency", 32'(lat), 32'(elat));
            check("quotient_lit", 32'(quotient), 32'(eq));
            check("remainder_lit", 32'(remainder), 32'(er));
            check("dbz_lit", 32'(div_by_zero), 32'(ez));
            last_done_cyc = cyc;
        end
        tick();
        if (!keep) start = 1'b0;
    endtask

    initial begin
        int pulses;
        int d1;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        tick();

        do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, N + 1, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) pulses++;
            tick();
        end
        check("no_retrigger", 32'(pulses), 0);

        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, N + 1, 1'b0, 1'b0);
        tick();
        do_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, N + 1, 1'b0, 1'b0);
        tick();
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, N + 1, 1'b0, 1'b0);
        tick();
        do_div(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, 1'b0, 1'b0);
        tick();
        tick();
        do_div(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, N + 1, 1'b1, 1'b0);
        tick();

        do_div(8'd20, 8'd3, 8'd6, 8'd2, 1'b0, N + 1, 1'b0, 1'b1);
        d1 = last_done_cyc;
        do_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, N + 1, 1'b0, 1'b0);
        check("b2b_spacing", 32'(last_done_cyc - d1), 32'(N + 2));
        tick();

        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrun_rst_stall", 32'(stall), 0);
        check("midrun_rst_done", 32'(done), 0);
        check("midrun_rst_quotient", 32'(quotient), 0);
        check("midrun_rst_remainder", 32'(remainder), 0);
        check("midrun_rst_dbz", 32'(div_by_zero), 0);
        tick();

        do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, N + 1, 1'b0, 1'b0);
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
